// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register with immediate pre-decode and 2-entry skid buffer
module if_id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc4,
  output logic [15:0] out_imm16,
  output logic [1:0]  out_extop,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  localparam logic [1:0] EXT_ZERO    = 2'b00;
  localparam logic [1:0] EXT_SIGNED  = 2'b01;
  localparam logic [1:0] EXT_HIGHPOS = 2'b10;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [15:0] imm16;
    logic [1:0]  extop;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        illegal;
  } entry_t;

  entry_t head, skid, head_n, skid_n, incoming;
  logic   accept, pop;

  // Pre-decode happens before storage so decode sees only registered fields.
  always_comb begin
    incoming         = '0;
    incoming.valid   = 1'b1;
    incoming.instr   = in_instr;
    incoming.pc4     = in_pc + 32'd4;
    incoming.imm16   = in_instr[15:0];
    incoming.rs      = in_instr[25:21];
    incoming.rt      = in_instr[20:16];
    incoming.rd      = in_instr[15:11];
    incoming.extop   = EXT_SIGNED;
    incoming.illegal = 1'b0;
    case (in_instr[31:26])
      6'b001100, 6'b001101, 6'b001110: incoming.extop = EXT_ZERO;
      6'b001111:                       incoming.extop = EXT_HIGHPOS;
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b100011, 6'b101011, 6'b000100, 6'b000101,
      6'b000000, 6'b000010, 6'b000011: incoming.extop = EXT_SIGNED;
      default:                         incoming.illegal = 1'b1;
    endcase
  end

  assign accept = in_valid & in_ready;
  assign pop    = head.valid & out_ready;

  always_comb begin
    head_n = head;
    skid_n = skid;
    if (flush) begin
      head_n.valid = 1'b0;
      skid_n.valid = 1'b0;
    end else if (pop && skid.valid) begin
      head_n = skid;
      if (accept) skid_n = incoming;
      else        skid_n.valid = 1'b0;
    end else if (pop) begin
      if (accept) head_n = incoming;
      else        head_n.valid = 1'b0;
    end else if (accept) begin
      if (!head.valid) head_n = incoming;
      else             skid_n = incoming;
    end
  end

  // Ready is registered from the next skid state, so fetch never sees a combinational path from decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      skid     <= '0;
      in_ready <= 1'b0;
    end else begin
      head     <= head_n;
      skid     <= skid_n;
      in_ready <= ~skid_n.valid;
    end
  end

  assign out_valid   = head.valid;
  assign out_instr   = head.instr;
  assign out_pc4     = head.pc4;
  assign out_imm16   = head.imm16;
  assign out_extop   = head.extop;
  assign out_rs      = head.rs;
  assign out_rt      = head.rt;
  assign out_rd      = head.rd;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed and random checks of if_id_stage against a queue model
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_instr, out_pc4;
  logic [15:0] out_imm16;
  logic [1:0]  out_extop;
  logic [4:0]  out_rs, out_rt, out_rd;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] qi[$];
  logic [31:0] qp[$];
  logic        mready;

  if_id_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc4(out_pc4),
    .out_imm16(out_imm16), .out_extop(out_extop), .out_rs(out_rs),
    .out_rt(out_rt), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_extop(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    if (op == 6'h0C || op == 6'h0D || op == 6'h0E) return 2'b00;
    if (op == 6'h0F) return 2'b10;
    return 2'b01;
  endfunction

  function automatic logic ref_illegal(input logic [31:0] ins);
    logic [5:0] legal [15] = '{6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h08, 6'h09, 6'h0A, 6'h0B,
                               6'h23, 6'h2B, 6'h04, 6'h05, 6'h00, 6'h02, 6'h03};
    foreach (legal[i]) if (legal[i] == ins[31:26]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_all();
    chk("out_valid", {31'd0, out_valid}, {31'd0, qi.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, mready});
    if (qi.size() > 0) begin
      chk("instr", out_instr, qi[0]);
      chk("pc4", out_pc4, qp[0] + 32'd4);
      chk("imm16", {16'd0, out_imm16}, {16'd0, qi[0][15:0]});
      chk("extop", {30'd0, out_extop}, {30'd0, ref_extop(qi[0])});
      chk("rs_rt_rd", {17'd0, out_rs, out_rt, out_rd}, {17'd0, qi[0][25:11]});
      chk("illegal", {31'd0, out_illegal}, {31'd0, ref_illegal(qi[0])});
    end
  endtask

  // One clock: drive inputs, advance the queue model at the edge, compare just after it.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                      input logic fl, input logic ordy, output logic acc);
    logic pp;
    in_valid = iv; in_instr = ins; in_pc = pc; flush = fl; out_ready = ordy;
    @(posedge clk);
    acc = iv && mready;
    pp  = ordy && (qi.size() > 0);
    if (fl) begin
      qi.delete(); qp.delete();
    end else begin
      if (pp) begin void'(qi.pop_front()); void'(qp.pop_front()); end
      if (acc) begin qi.push_back(ins); qp.push_back(pc); end
    end
    mready = qi.size() < 2;
    #1 check_all();
  endtask

  initial begin
    logic        acc;
    logic [31:0] arr [3];
    logic [31:0] r, pc;
    logic [5:0]  ops [16] = '{6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h08, 6'h09, 6'h0A, 6'h0B,
                              6'h23, 6'h2B, 6'h04, 6'h05, 6'h00, 6'h02, 6'h3F, 6'h11};
    int k;

    rst = 1'b1; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0; out_ready = 0;
    mready = 1'b0;
    #7;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_pc4", out_pc4, 32'd0);
    chk("rst_extop_illegal", {29'd0, out_extop, out_illegal}, 32'd0);
    rst = 1'b0;
    step(0, 0, 0, 0, 1, acc);

    // extop decode, each instruction held in head for one cycle
    step(1, 32'h3508_8000, 32'h100, 0, 1, acc);
    chk("ori_extop", {30'd0, out_extop}, 32'd0);
    chk("ori_imm16", {16'd0, out_imm16}, 32'h8000);
    chk("ori_rs_rt", {22'd0, out_rs, out_rt}, {22'd0, 5'd8, 5'd8});
    step(1, 32'h3C01_1234, 32'h104, 0, 1, acc);
    chk("lui_extop", {30'd0, out_extop}, 32'd2);
    step(1, 32'h8C22_FFFC, 32'h108, 0, 1, acc);
    chk("lw_extop", {30'd0, out_extop}, 32'd1);
    step(1, 32'hFC00_0000, 32'h10C, 0, 1, acc);
    chk("ill_flag", {30'd0, out_extop, out_illegal}, 32'd3);
    step(1, 32'h0000_0020, 32'hFFFF_FFFC, 0, 1, acc);
    chk("wrap_pc4", out_pc4, 32'd0);
    step(0, 0, 0, 0, 1, acc);

    // streaming at one per cycle
    for (int i = 0; i < 8; i++) begin
      step(1, 32'h2000_0000 + i, 32'h0040_0000 + 4 * i, 0, 1, acc);
      chk("stream_pc4", out_pc4, 32'h0040_0004 + 4 * i);
    end
    step(0, 0, 0, 0, 1, acc);

    // backpressure with fetch holding C
    arr[0] = 32'h2401_000A; arr[1] = 32'h2402_000B; arr[2] = 32'h2403_000C;
    k = 0;
    for (int i = 0; i < 11; i++) begin
      step(k < 3, (k < 3) ? arr[k] : 32'd0, 32'h200 + 4 * k, 0, i >= 5, acc);
      if (acc) k++;
    end
    chk("bp_all_accepted", k, 3);

    // flush with head and skid full and an incoming instruction
    step(1, 32'h2404_0001, 32'h300, 0, 0, acc);
    step(1, 32'h2405_0002, 32'h304, 0, 0, acc);
    step(1, 32'h2406_0003, 32'h308, 1, 0, acc);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, acc);
    step(0, 0, 0, 1, 1, acc);
    step(0, 0, 0, 0, 1, acc);

    // asynchronous reset with both entries full
    step(1, 32'h2407_0004, 32'h400, 0, 0, acc);
    step(1, 32'h2408_0005, 32'h404, 0, 0, acc);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    #2 rst = 1'b0;
    qi.delete(); qp.delete(); mready = 1'b0;
    step(0, 0, 0, 0, 0, acc);

    // random traffic
    k = 0;
    r = $urandom(); pc = {r[31:2], 2'b00};
    r = $urandom(); arr[0] = {ops[$urandom_range(15)], r[25:0]};
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(3) != 0, arr[0], pc, $urandom_range(15) == 0,
           $urandom_range(1) == 1, acc);
      if (acc) begin
        pc = pc + 32'd4;
        r = $urandom(); arr[0] = {ops[$urandom_range(15)], r[25:0]};
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
